cmac_tx_pkt_gen: RTL and testbench

Frame generator for the 512-bit CMAC TX AXI-Stream path. It drives the `*_mac_tx_axis_*` interface of a CMAC, or of its simulation model, with a programmable burst of frames carrying a self-checking payload: sequence number, length, and an incrementing byte pattern. It sits on the transmit side of the loopback, upstream of the MAC. The receive-side checker uses the same payload format to validate frames that come back on `*_rx_axis_*`.

---
 rtl/cmac_tx_pkt_gen.sv | 149 ++++++++++++++
 tb/tb_cmac_tx_pkt_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cmac_tx_pkt_gen.sv
// Burst frame generator for the 512-bit CMAC TX AXI-Stream path.
// Payload: 32-bit sequence number, 16-bit length, then byte n = n[7:0].
module cmac_tx_pkt_gen #(
   parameter int LEN_W   = 14,
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 9600,
   parameter int CNT_W   = 32,
   parameter int IFG_W   = 8
) (
   input  logic               tx_clk_int,
   input  logic               tx_rst_int,
   input  logic               start,
   input  logic               stop,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic [CNT_W-1:0]   cfg_cnt,
   input  logic [IFG_W-1:0]   cfg_ifg,
   input  logic               err_inject,
   output logic [511:0]       tx_axis_tdata,
   output logic [63:0]        tx_axis_tkeep,
   output logic               tx_axis_tlast,
   output logic               tx_axis_tuser,
   output logic               tx_axis_tvalid,
   input  logic               tx_axis_tready,
   output logic               busy,
   output logic [CNT_W-1:0]   frames_sent
);

   localparam int BEAT_W = LEN_W - 6;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t             state, state_nxt;
   logic [LEN_W-1:0]   len_q, len_clamped;
   logic [BEAT_W-1:0]  beat, last_beat;
   logic [31:0]        seq;
   logic [CNT_W-1:0]   cnt_q, run_cnt;
   logic [IFG_W-1:0]   ifg_q, gap_cnt;
   logic               stop_req, err_q;
   logic               frame_end, run_done, stop_any;
   logic [5:0]         rem;

   always_comb begin
      len_clamped = cfg_len;
      if (cfg_len < LEN_W'(MIN_LEN))
         len_clamped = LEN_W'(MIN_LEN);
      else if (cfg_len > LEN_W'(MAX_LEN))
         len_clamped = LEN_W'(MAX_LEN);
   end

   assign last_beat = BEAT_W'((len_q - LEN_W'(1)) >> 6);
   assign rem       = len_q[5:0];
   assign frame_end = (state == SEND) && tx_axis_tready && (beat == last_beat);
   // stop is a level but may be pulsed mid-frame, so it is remembered until the run ends
   assign stop_any  = stop || stop_req;
   assign run_done  = stop_any || ((cnt_q != '0) && (run_cnt + CNT_W'(1) == cnt_q));

   always_ff @(posedge tx_clk_int or posedge tx_rst_int) begin
      if (tx_rst_int)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = SEND;
         SEND: begin
            if (frame_end) begin
               if (run_done)
                  state_nxt = IDLE;
               else if (ifg_q != '0)
                  state_nxt = GAP;
               else
                  state_nxt = SEND;
            end
         end
         GAP: if (gap_cnt == IFG_W'(1)) state_nxt = stop_any ? IDLE : SEND;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge tx_clk_int or posedge tx_rst_int) begin
      if (tx_rst_int) begin
         len_q       <= '0;
         cnt_q       <= '0;
         ifg_q       <= '0;
         beat        <= '0;
         seq         <= '0;
         run_cnt     <= '0;
         gap_cnt     <= '0;
         stop_req    <= 1'b0;
         err_q       <= 1'b0;
         frames_sent <= '0;
      end else begin
         if (state == IDLE) begin
            stop_req <= 1'b0;
            if (start) begin
               len_q   <= len_clamped;
               cnt_q   <= cfg_cnt;
               ifg_q   <= cfg_ifg;
               seq     <= '0;
               run_cnt <= '0;
               beat    <= '0;
            end
         end else if (stop) begin
            stop_req <= 1'b1;
         end
         if (state == SEND && tx_axis_tready) begin
            if (beat == last_beat) begin
               beat        <= '0;
               seq         <= seq + 32'd1;
               run_cnt     <= run_cnt + CNT_W'(1);
               frames_sent <= frames_sent + CNT_W'(1);
               gap_cnt     <= ifg_q;
            end else begin
               beat <= beat + BEAT_W'(1);
            end
         end
         if (state == GAP)
            gap_cnt <= gap_cnt - IFG_W'(1);
         // error flag is captured as each frame's first beat is presented and held for the frame
         if (state_nxt == SEND && (state != SEND || frame_end))
            err_q <= err_inject;
      end
   end

   always_comb begin
      tx_axis_tvalid = (state == SEND);
      busy           = (state != IDLE);
      tx_axis_tlast  = tx_axis_tvalid && (beat == last_beat);
      tx_axis_tuser  = tx_axis_tlast && err_q;
      tx_axis_tdata  = '0;
      tx_axis_tkeep  = '0;
      for (int j = 0; j < 64; j++) begin
         tx_axis_tdata[8*j +: 8] = {beat[1:0], 6'(j)};
         tx_axis_tkeep[j]        = !tx_axis_tlast || (rem == 6'd0) || (6'(j) < rem);
      end
      if (beat == '0) begin
         tx_axis_tdata[31:0]  = seq;
         tx_axis_tdata[47:32] = 16'(len_q);
      end
      if (!tx_axis_tvalid) begin
         tx_axis_tdata = '0;
         tx_axis_tkeep = '0;
      end
   end

endmodule

// File: tb/tb_cmac_tx_pkt_gen.sv
// Bench for cmac_tx_pkt_gen: table-driven runs plus random runs checked
// against a byte-level frame model, and a mid-frame reset sequence.
module tb_cmac_tx_pkt_gen;

   logic          clk = 1'b0;
   logic          rst, start, stop, err_inject, tready;
   logic [13:0]   cfg_len;
   logic [31:0]   cfg_cnt;
   logic [7:0]    cfg_ifg;
   logic [511:0]  tdata;
   logic [63:0]   tkeep;
   logic          tlast, tuser, tvalid, busy;
   logic [31:0]   frames_sent;

   int checks = 0;
   int errors = 0;
   int sent_total = 0;

   always #5 clk = ~clk;

   cmac_tx_pkt_gen dut (
      .tx_clk_int     (clk),
      .tx_rst_int     (rst),
      .start          (start),
      .stop           (stop),
      .cfg_len        (cfg_len),
      .cfg_cnt        (cfg_cnt),
      .cfg_ifg        (cfg_ifg),
      .err_inject     (err_inject),
      .tx_axis_tdata  (tdata),
      .tx_axis_tkeep  (tkeep),
      .tx_axis_tlast  (tlast),
      .tx_axis_tuser  (tuser),
      .tx_axis_tvalid (tvalid),
      .tx_axis_tready (tready),
      .busy           (busy),
      .frames_sent    (frames_sent)
   );

   typedef struct {
      int          len;
      int          cnt;
      int          ifg;
      bit          err;
      bit          rnd;
      int          stop_frame;
      int          exp_frames;
      int          exp_beats;
      logic [15:0] exp_lenf;
      logic [63:0] exp_keep;
   } vec_t;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int eff_len(input int l);
      if (l < 64) return 64;
      if (l > 9600) return 9600;
      return l;
   endfunction

   function automatic logic [511:0] exp_data(input int seq, input int len, input int k);
      logic [511:0] d;
      int n;
      d = '0;
      for (int j = 0; j < 64; j++) begin
         n = 64 * k + j;
         if (n < 4)      d[8*j +: 8] = 8'((seq >> (8 * n)) & 255);
         else if (n < 6) d[8*j +: 8] = 8'((len >> (8 * (n - 4))) & 255);
         else            d[8*j +: 8] = 8'(n & 255);
      end
      return d;
   endfunction

   function automatic logic [63:0] exp_keep(input int len, input int k);
      logic [63:0] m;
      for (int j = 0; j < 64; j++) m[j] = (64 * k + j < len);
      return m;
   endfunction

   function automatic logic [511:0] byte_mask(input logic [63:0] m);
      logic [511:0] d;
      for (int j = 0; j < 64; j++) d[8*j +: 8] = {8{m[j]}};
      return d;
   endfunction

   task automatic run(input vec_t v);
      int L, B, fr, k, idle, cyc;
      bit ended, seen_valid;
      logic [63:0] km;
      L = eff_len(v.len);
      B = (L + 63) / 64;
      fr = 0; k = 0; idle = 0; cyc = 0; ended = 0;
      @(posedge clk); #1;
      cfg_len = 14'(v.len); cfg_cnt = 32'(v.cnt); cfg_ifg = 8'(v.ifg);
      err_inject = v.err; start = 1'b1;
      tready = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("start_latency", 512'({tvalid, busy}), 512'(2'b11));
      while (cyc < 20000) begin
         if (tvalid) begin
            if (ended) begin
               check("ifg_idle", 512'(idle), 512'(v.ifg));
               ended = 0;
            end
            km = exp_keep(L, k);
            check("beat_data", tdata & byte_mask(km), exp_data(fr, L, k) & byte_mask(km));
            check("beat_ctl", 512'({tkeep, tlast, tuser}),
                  512'({km, (k == B - 1), (k == B - 1) && v.err}));
            if (fr == 0 && k == 0 && v.exp_beats > 0)
               check("len_field", 512'(tdata[47:32]), 512'(v.exp_lenf));
            if (tready) begin
               if (fr == 0 && k == B - 1 && v.exp_beats > 0) begin
                  check("beats_per_frame", 512'(k + 1), 512'(v.exp_beats));
                  check("last_keep", 512'(tkeep), 512'(v.exp_keep));
               end
               if (k == B - 1) begin
                  fr++; k = 0; ended = 1; idle = 0; sent_total++;
               end else begin
                  k++;
               end
            end
         end else begin
            check("no_midframe_bubble", 512'(k), 512'(0));
            if (!busy) break;
            idle++;
         end
         @(posedge clk); #1;
         tready = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         stop = (v.stop_frame >= 0) && (fr == v.stop_frame) && (k == 1);
         @(negedge clk);
         cyc++;
      end
      stop = 1'b0;
      check("run_timeout", 512'(cyc >= 20000), 512'(0));
      check("frame_count", 512'(fr), 512'(v.exp_frames));
      check("frames_sent", 512'(frames_sent), 512'(sent_total));
      check("busy_end", 512'(busy), 512'(0));
      seen_valid = 0;
      repeat (4) begin
         @(negedge clk);
         if (tvalid) seen_valid = 1;
      end
      check("quiet_after_run", 512'(seen_valid), 512'(0));
   endtask

   vec_t tbl[7];
   vec_t rv;

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; err_inject = 1'b0; tready = 1'b1;
      cfg_len = '0; cfg_cnt = '0; cfg_ifg = '0;

      tbl[0] = '{64,   1, 0, 1'b0, 1'b0, -1, 1, 1,   16'h0040, {64{1'b1}}};
      tbl[1] = '{65,   2, 3, 1'b0, 1'b0, -1, 2, 2,   16'h0041, 64'h1};
      tbl[2] = '{200,  3, 1, 1'b1, 1'b1, -1, 3, 4,   16'h00C8, 64'hFF};
      tbl[3] = '{10,   1, 0, 1'b0, 1'b0, -1, 1, 1,   16'h0040, {64{1'b1}}};
      tbl[4] = '{9700, 1, 0, 1'b0, 1'b1, -1, 1, 150, 16'h2580, {64{1'b1}}};
      tbl[5] = '{200,  0, 2, 1'b0, 1'b0,  3, 4, 4,   16'h00C8, 64'hFF};
      tbl[6] = '{128,  2, 0, 1'b1, 1'b0, -1, 2, 2,   16'h0080, {64{1'b1}}};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctl", 512'({tvalid, tlast, tuser, busy}), 512'(0));
      check("reset_data", tdata, 512'(0));
      check("reset_keep_cnt", 512'({tkeep, frames_sent}), 512'(0));
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < 7; i++) run(tbl[i]);

      for (int i = 0; i < 6; i++) begin
         rv.len = $urandom_range(1, 700);
         rv.cnt = $urandom_range(1, 3);
         rv.ifg = $urandom_range(0, 4);
         rv.err = 1'($urandom_range(0, 1));
         rv.rnd = 1'b1;
         rv.stop_frame = -1;
         rv.exp_frames = rv.cnt;
         rv.exp_beats = -1;
         rv.exp_lenf = '0;
         rv.exp_keep = '0;
         run(rv);
      end

      // reset in the middle of an errored frame, then a clean restart
      @(posedge clk); #1;
      cfg_len = 14'd300; cfg_cnt = 32'd1; cfg_ifg = 8'd0; err_inject = 1'b1;
      tready = 1'b1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 tready = 1'b0;
      @(negedge clk);
      check("pre_reset_valid", 512'({tvalid, busy}), 512'(2'b11));
      #2 rst = 1'b1;
      #1;
      check("async_reset_ctl", 512'({tvalid, tlast, tuser, busy}), 512'(0));
      check("async_reset_data", tdata, 512'(0));
      check("async_reset_keep_cnt", 512'({tkeep, frames_sent}), 512'(0));
      @(posedge clk); #1 rst = 1'b0;
      sent_total = 0;
      rv = '{64, 1, 0, 1'b0, 1'b0, -1, 1, 1, 16'h0040, {64{1'b1}}};
      run(rv);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
